seq_divider: RTL

- Multi-cycle 64-bit integer divider for the execute stage; implements UDIV and SDIV by iterative restoring shift-subtract, one quotient bit per cycle.
- Subtraction is the inverse use of the datapath adder: A + ~B + 1, carry-out meaning "no borrow".
- The pipeline raises start and holds the stage while busy is high.
- Quotient and remainder are captured when done pulses.

---
 rtl/div_pkg.sv | 6 +
 rtl/seq_divider_if.sv | 17 +
 rtl/div_step.sv | 17 +
 rtl/seq_divider.sv | 101 ++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative integer divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;
    localparam int DIV_WIDTH = 64;
    localparam int CNT_W     = $clog2(DIV_WIDTH);
endpackage

// File: rtl/seq_divider_if.sv
// Pipeline-to-divider request/result bundle.
interface seq_divider_if import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (output start, signed_op, dividend, divisor,
                    input  busy, done, quotient, remainder, div_by_zero);
    modport slave  (input  start, signed_op, dividend, divisor,
                    output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration; subtraction is A + ~B + 1 with carry = no borrow.
module div_step #(parameter int WIDTH = 64) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] sum;

    assign shifted = {rem, bit_in};
    assign sum     = {1'b0, shifted} + {1'b0, ~{1'b0, dsr}} + {{(WIDTH+1){1'b0}}, 1'b1};
    // With a nonzero divisor a kept difference always fits in WIDTH bits, so bit WIDTH is clear.
    assign q_bit    = sum[WIDTH+1] & ~sum[WIDTH];
    assign rem_next = q_bit ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle UDIV/SDIV: magnitudes divided one bit per cycle, signs and div-by-zero fixed up at the end.
module seq_divider import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
    input  logic         clk,
    input  logic         reset_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    div_state_t       state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] prem, prem_nx, dvd, dsr, dvd_orig, a_mag, b_mag;
    logic [WIDTH-1:0] q_r, r_r;
    logic             neg_q, neg_r, dz, dz_r, q_bit, load, busy, done;

    assign a_mag = (bus.signed_op && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign b_mag = (bus.signed_op && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (prem),
        .bit_in   (dvd[WIDTH-1]),
        .dsr      (dsr),
        .rem_next (prem_nx),
        .q_bit    (q_bit)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                load     = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = FIX;
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            prem     <= '0;
            dvd      <= '0;
            dsr      <= '0;
            dvd_orig <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            q_r      <= '0;
            r_r      <= '0;
            dz_r     <= 1'b0;
        end else if (load) begin
            neg_q    <= bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_r    <= bus.signed_op & bus.dividend[WIDTH-1];
            dz       <= (bus.divisor == '0);
            dvd_orig <= bus.dividend;
            dvd      <= a_mag;
            dsr      <= b_mag;
            prem     <= '0;
            cnt      <= CW'(WIDTH-1);
        end else if (state == RUN) begin
            // Quotient bits shift in behind the dividend bits as they are consumed.
            prem <= prem_nx;
            dvd  <= {dvd[WIDTH-2:0], q_bit};
            cnt  <= cnt - 1'b1;
        end else if (state == FIX) begin
            dz_r <= dz;
            q_r  <= dz ? '0 : (neg_q ? -dvd : dvd);
            r_r  <= dz ? dvd_orig : (neg_r ? -prem : prem);
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.quotient    = q_r;
    assign bus.remainder   = r_r;
    assign bus.div_by_zero = dz_r;
endmodule
